// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB lookup/refill controller: block layout, FSM states, width helpers.
package tlb_pkg;

  localparam int BLK_W   = 64;
  localparam int PPN_LSB = 0;

  // IDLE accept | LOOKUP tag compare | WALK_REQ walk handshake | WALK_WAIT await walker | RESP hold response
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WALK_REQ,
    S_WALK_WAIT,
    S_RESP
  } tlb_state_e;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int vpn_w);
    return vpn_w - $clog2(sets);
  endfunction

  function automatic int tag_lsb(input int ppn_w);
    return ppn_w;
  endfunction

  function automatic int valid_bit(input int sets, input int vpn_w, input int ppn_w);
    return ppn_w + tag_w(sets, vpn_w);
  endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// Victim way choice for a refill: lowest invalid way, else the set's round-robin pointer.
module tlb_victim_sel
  import tlb_pkg::*;
#(
  parameter  int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  i_valid,
  input  logic [WAY_W-1:0] i_rr_ptr,
  output logic [WAY_W-1:0] o_victim,
  output logic [WAY_W-1:0] o_next_ptr
);

  // Descending scan so the lowest invalid way ends up selected; the pointer
  // only moves when a valid entry gets replaced.
  always_comb begin
    o_victim   = i_rr_ptr;
    o_next_ptr = i_rr_ptr + WAY_W'(1);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) begin
        o_victim   = WAY_W'(w);
        o_next_ptr = i_rr_ptr;
      end
    end
  end

endmodule

// File: rtl/tlb_lookup_ctrl.sv
// Set-associative TLB lookup and page-walk refill controller.
// Optional hit/miss counters are enabled by defining TLB_STATS_EN.
module tlb_lookup_ctrl
  import tlb_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int WAYS  = 4,
  parameter int VPN_W = 20,
  parameter int PPN_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [VPN_W-1:0] req_vpn,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_hit,
  output logic [PPN_W-1:0] resp_ppn,
  output logic             resp_fault,
  output logic             walk_req_valid,
  input  logic             walk_req_ready,
  output logic [VPN_W-1:0] walk_req_vpn,
  input  logic             walk_resp_valid,
  input  logic [PPN_W-1:0] walk_resp_ppn,
  input  logic             walk_resp_fault,
  input  logic             flush
`ifdef TLB_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);

  localparam int IDX_W     = idx_w(SETS);
  localparam int TAG_W     = tag_w(SETS, VPN_W);
  localparam int WAY_W     = $clog2(WAYS);
  localparam int TAG_LSB   = tag_lsb(PPN_W);
  localparam int VALID_BIT = valid_bit(SETS, VPN_W, PPN_W);
  localparam int PAD_W     = BLK_W - VALID_BIT;

  tlb_state_e       r_state;
  logic [VPN_W-1:0] r_vpn;
  logic [BLK_W-1:0] r_blk [SETS][WAYS];
  logic [WAY_W-1:0] r_rr [SETS];
  logic             r_resp_hit;
  logic             r_resp_fault;
  logic [PPN_W-1:0] r_resp_ppn;
  logic             r_flush_seen;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [WAYS-1:0]  w_way_valid;
  logic             w_hit;
  logic [PPN_W-1:0] w_hit_ppn;
  logic [WAY_W-1:0] w_victim;
  logic [WAY_W-1:0] w_next_rr;
  logic             w_resp_now;
  logic             w_walk_done;
  logic             w_install;
  logic             w_in_resp;

  assign w_idx = r_vpn[IDX_W-1:0];
  assign w_tag = r_vpn[VPN_W-1:IDX_W];

  // An entry is live only with its valid bit set and the padding clear.
  always_comb begin
    w_way_valid = '0;
    w_hit       = 1'b0;
    w_hit_ppn   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_way_valid[w] = (r_blk[w_idx][w][BLK_W-1:VALID_BIT] == PAD_W'(1));
      if (w_way_valid[w] && (r_blk[w_idx][w][TAG_LSB +: TAG_W] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_ppn = r_blk[w_idx][w][PPN_LSB +: PPN_W];
      end
    end
  end

  tlb_victim_sel #(.WAYS(WAYS)) u_victim_sel (
    .i_valid    (w_way_valid),
    .i_rr_ptr   (r_rr[w_idx]),
    .o_victim   (w_victim),
    .o_next_ptr (w_next_rr)
  );

  assign w_in_resp   = (r_state == S_RESP);
  assign w_resp_now  = (r_state == S_LOOKUP) && w_hit;
  assign w_walk_done = (r_state == S_WALK_WAIT) && walk_resp_valid;
  assign w_install   = w_walk_done && !walk_resp_fault && !flush && !r_flush_seen;

  // Responses are presented combinationally in LOOKUP/WALK_WAIT, but the
  // consumer handshake only completes in RESP, where the registered copy is held.
  assign req_ready      = (r_state == S_IDLE);
  assign resp_valid     = w_resp_now || w_walk_done || w_in_resp;
  assign resp_hit       = w_resp_now || (w_in_resp && r_resp_hit);
  assign resp_fault     = w_walk_done ? walk_resp_fault : (w_in_resp && r_resp_fault);
  assign resp_ppn       = w_resp_now  ? w_hit_ppn :
                          w_walk_done ? (walk_resp_fault ? '0 : walk_resp_ppn) :
                          w_in_resp   ? r_resp_ppn : '0;
  assign walk_req_valid = ((r_state == S_LOOKUP) && !w_hit) || (r_state == S_WALK_REQ);
  assign walk_req_vpn   = walk_req_valid ? r_vpn : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_vpn        <= '0;
      r_resp_hit   <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_ppn   <= '0;
      r_flush_seen <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_blk[s][w] <= '0;
      end
    end else begin
      if (flush) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) r_blk[s][w][VALID_BIT] <= 1'b0;
      end
      if (w_install) begin
        r_blk[w_idx][w_victim] <= BLK_W'({1'b1, w_tag, walk_resp_ppn});
        r_rr[w_idx]            <= w_next_rr;
      end
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_vpn   <= req_vpn;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_resp_hit   <= 1'b1;
            r_resp_fault <= 1'b0;
            r_resp_ppn   <= w_hit_ppn;
            r_state      <= S_RESP;
          end else begin
            r_state <= S_WALK_REQ;
          end
        end
        S_WALK_REQ: begin
          if (walk_req_ready) begin
            r_flush_seen <= 1'b0;
            r_state      <= S_WALK_WAIT;
          end
        end
        S_WALK_WAIT: begin
          if (flush) r_flush_seen <= 1'b1;
          if (walk_resp_valid) begin
            r_resp_hit   <= 1'b0;
            r_resp_fault <= walk_resp_fault;
            r_resp_ppn   <= walk_resp_fault ? '0 : walk_resp_ppn;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_hit   <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_ppn   <= '0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef TLB_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_tlb_lookup_ctrl.sv
// Directed bench for tlb_lookup_ctrl: hits, misses, eviction, faults, backpressure, flush, reset.
module tb_tlb_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [19:0] req_vpn = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_hit;
  logic [19:0] resp_ppn;
  logic        resp_fault;
  logic        walk_req_valid;
  logic        walk_req_ready = 1'b0;
  logic [19:0] walk_req_vpn;
  logic        walk_resp_valid = 1'b0;
  logic [19:0] walk_resp_ppn = '0;
  logic        walk_resp_fault = 1'b0;
  logic        flush = 1'b0;
`ifdef TLB_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tlb_lookup_ctrl #(.SETS(16), .WAYS(4), .VPN_W(20), .PPN_W(20)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_vpn         (req_vpn),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_hit        (resp_hit),
    .resp_ppn        (resp_ppn),
    .resp_fault      (resp_fault),
    .walk_req_valid  (walk_req_valid),
    .walk_req_ready  (walk_req_ready),
    .walk_req_vpn    (walk_req_vpn),
    .walk_resp_valid (walk_resp_valid),
    .walk_resp_ppn   (walk_resp_ppn),
    .walk_resp_fault (walk_resp_fault),
    .flush           (flush)
`ifdef TLB_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [19:0] vpn);
    int k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_vpn   = vpn;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic end_resp();
    int k = 0;
    resp_ready = 1'b1;
    @(negedge clk);
    while (!req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("resp_release", 32'(req_ready), 32'd1);
    resp_ready = 1'b0;
  endtask

  task automatic expect_hit(input string tag, input logic [19:0] vpn, input logic [19:0] ppn);
    do_req(vpn);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_hit"}, 32'(resp_hit), 32'd1);
    chk({tag, "_ppn"}, 32'(resp_ppn), 32'(ppn));
    end_resp();
  endtask

  task automatic serve_miss(input string tag, input logic [19:0] vpn, input logic [19:0] ppn,
                            input logic fault, input int wait_cycles, input int stall,
                            input logic flush_mid);
    do_req(vpn);
    chk({tag, "_walk_valid"}, 32'(walk_req_valid), 32'd1);
    chk({tag, "_walk_vpn"}, 32'(walk_req_vpn), 32'(vpn));
    chk({tag, "_no_early_resp"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_stall_valid"}, 32'(walk_req_valid), 32'd1);
      chk({tag, "_stall_vpn"}, 32'(walk_req_vpn), 32'(vpn));
      @(negedge clk);
    end
    walk_req_ready = 1'b1;
    @(negedge clk);
    walk_req_ready = 1'b0;
    chk({tag, "_walk_dropped"}, 32'(walk_req_valid), 32'd0);
    for (int i = 0; i < wait_cycles; i++) begin
      flush = flush_mid && (i == 0);
      @(negedge clk);
    end
    flush = 1'b0;
    walk_resp_valid = 1'b1;
    walk_resp_ppn   = ppn;
    walk_resp_fault = fault;
    #1;
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_resp_hit"}, 32'(resp_hit), 32'd0);
    chk({tag, "_resp_ppn"}, 32'(resp_ppn), fault ? 32'd0 : 32'(ppn));
    chk({tag, "_resp_fault"}, 32'(resp_fault), 32'(fault));
    @(negedge clk);
    walk_resp_valid = 1'b0;
    walk_resp_fault = 1'b0;
    walk_resp_ppn   = '0;
    chk({tag, "_held_ppn"}, 32'(resp_ppn), fault ? 32'd0 : 32'(ppn));
    chk({tag, "_held_fault"}, 32'(resp_fault), 32'(fault));
    end_resp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_walk_valid", 32'(walk_req_valid), 32'd0);
    chk("rst_resp_ppn", 32'(resp_ppn), 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);

    // Cold miss, then hits with 1-cycle latency; second hit under backpressure
    serve_miss("cold", 20'h00012, 20'h0ABCD, 1'b0, 3, 0, 1'b0);
    expect_hit("warm", 20'h00012, 20'h0ABCD);
    do_req(20'h00012);
    chk("bp_valid", 32'(resp_valid), 32'd1);
    chk("bp_ppn", 32'(resp_ppn), 32'h0ABCD);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_hit", 32'(resp_hit), 32'd1);
      chk("bp_hold_ppn", 32'(resp_ppn), 32'h0ABCD);
      chk("bp_req_ready_low", 32'(req_ready), 32'd0);
    end
    end_resp();
`ifdef TLB_STATS_EN
    chk("stats_hits", hit_count, 32'd2);
    chk("stats_misses", miss_count, 32'd1);
`endif

    // Set conflict on index 0: fifth fill evicts way 0 (VPN 0x10)
    serve_miss("fill10", 20'h00010, 20'h00101, 1'b0, 1, 0, 1'b0);
    serve_miss("fill20", 20'h00020, 20'h00202, 1'b0, 1, 0, 1'b0);
    serve_miss("fill30", 20'h00030, 20'h00303, 1'b0, 1, 0, 1'b0);
    serve_miss("fill40", 20'h00040, 20'h00404, 1'b0, 1, 0, 1'b0);
    serve_miss("fill50", 20'h00050, 20'h00505, 1'b0, 1, 0, 1'b0);
    expect_hit("keep20", 20'h00020, 20'h00202);
    expect_hit("keep50", 20'h00050, 20'h00505);
    serve_miss("evict10", 20'h00010, 20'h00111, 1'b0, 2, 4, 1'b0);

    // Fault is not installed, so the next request walks again
    serve_miss("fault77", 20'h00077, 20'h12345, 1'b1, 2, 0, 1'b0);
    serve_miss("rewalk77", 20'h00077, 20'h07777, 1'b0, 1, 0, 1'b0);
    expect_hit("hit77", 20'h00077, 20'h07777);

    // Flush during WALK_WAIT: response delivered, install suppressed, all entries gone
    expect_hit("pre_flush12", 20'h00012, 20'h0ABCD);
    serve_miss("flush33", 20'h00033, 20'h0C0DE, 1'b0, 2, 0, 1'b1);
    serve_miss("post_flush33", 20'h00033, 20'h0C0DF, 1'b0, 1, 0, 1'b0);
    serve_miss("post_flush12", 20'h00012, 20'h0ABCE, 1'b0, 1, 0, 1'b0);

    // Reset while waiting on a walk, then a stray walker response
    do_req(20'h00045);
    chk("rstw_walk_valid", 32'(walk_req_valid), 32'd1);
    @(negedge clk);
    walk_req_ready = 1'b1;
    @(negedge clk);
    walk_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_req_ready", 32'(req_ready), 32'd1);
    chk("rstw_walk_idle", 32'(walk_req_valid), 32'd0);
    chk("rstw_resp_idle", 32'(resp_valid), 32'd0);
`ifdef TLB_STATS_EN
    chk("rstw_hits_zero", hit_count, 32'd0);
    chk("rstw_misses_zero", miss_count, 32'd0);
`endif
    walk_resp_valid = 1'b1;
    walk_resp_ppn   = 20'h0DEAD;
    #1;
    chk("stray_no_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    walk_resp_valid = 1'b0;
    walk_resp_ppn   = '0;
    chk("stray_still_idle", 32'(req_ready), 32'd1);
    chk("stray_no_resp_after", 32'(resp_valid), 32'd0);
    serve_miss("rst_miss12", 20'h00012, 20'h00AAA, 1'b0, 1, 0, 1'b0);
    serve_miss("rst_miss77", 20'h00077, 20'h00BBB, 1'b0, 1, 0, 1'b0);
    expect_hit("rst_hit12", 20'h00012, 20'h00AAA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
